keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 active-low matrix keypad, debounces it and produces a
//   stable key code plus a debounced pressed level. Sits directly upstream
//   of the calculator control unit: button feeds its button input and
//   is_pressed_next feeds its is_pressed_next input. One accepted press
//   gives exactly one rising edge of is_pressed_next.
// PARAMETERS
//   SCAN_DIV        1000  clock cycles each column is driven (dwell); must be >= 4
//   DEBOUNCE_SCANS  4     consecutive identical full scans needed to accept a change; >= 1
// PORTS
//   clock            in   1  system clock, rising edge
//   reset            in   1  asynchronous, active-high
//   row              in   4  keypad rows, active-low, externally pulled up, asynchronous
//   col              out  4  keypad column drive, active-low, exactly one bit low
//   button           out  4  debounced key code (0-9, A=+, B=-, C=*, D=/, E==, F=clear)
//   is_pressed_next  out  1  debounced key-held level
//   key_valid        out  1  one-cycle pulse on each accepted press
// BEHAVIOUR
//   Reset (async) values:
//     col=4'b1110, button=0, is_pressed_next=0, key_valid=0.
//     Column index, dwell counter and stable counter = 0; state=IDLE;
//     previous scan result = "none"; synchronizer flops = 4'b1111.
//   Row synchronization: row passes through a 2-flop synchronizer before use.
//   Scan:
//     - col = ~(1<<cidx).
//     - Dwell counter runs 0..SCAN_DIV-1. The synchronized row is sampled
//       when the counter = SCAN_DIV-1; cidx then advances, wrapping 3->0.
//     - One full scan = 4*SCAN_DIV cycles.
//   Keymap (row r, col c), r=0..3:
//     r0: 1 2 3 A;  r1: 4 5 6 B;  r2: 7 8 9 C;  r3: F 0 E D
//   Scan result, evaluated at the end of the column-3 sample:
//     - exactly one low row bit over the whole scan -> key(code).
//     - zero low bits -> none.
//     - two or more low bits (any columns) -> none (ghost/multi-key rejection).
//   Debounce:
//     - If result == previous result, stable_cnt increments, saturating
//       at DEBOUNCE_SCANS; otherwise stable_cnt=1. Previous result is then updated.
//     - "Stable" = stable_cnt reaches DEBOUNCE_SCANS on this scan.
//   FSM, acting only at scan end:
//     - IDLE: stable key(code) -> PRESSED; button<=code,
//       is_pressed_next<=1 and key_valid<=1, all on the same edge.
//     - PRESSED: stable none -> IDLE; is_pressed_next<=0; button holds.
//     - PRESSED with a stable different key: ignored. The state stays
//       PRESSED and button is unchanged; a release (stable none) is
//       required before any new press.
//   key_valid is high for exactly one cycle; at all other times it is 0.
//   button changes only on press acceptance and otherwise holds its last
//   value, including while released.
//   Press latency: acceptance occurs at the end of the DEBOUNCE_SCANS-th
//   consecutive full scan that contains the key, i.e. at most
//   (DEBOUNCE_SCANS+1)*4*SCAN_DIV+2 cycles after the row goes stable.
//   Release latency has the same bound.
//   Reset mid-press: the outputs return to their reset values at once.
//   A key still held after reset is re-accepted after a full debounce
//   (new key_valid pulse).
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3 -> scan = 16 cycles)
//   1. Assert reset with row=4'hF -> col=1110, button=0, is_pressed_next=0,
//      key_valid=0; col then rotates 1110,1101,1011,0111 with 4 cycles each.
//   2. Model key r1c2 ('6') held stable -> within 66 cycles is_pressed_next=1,
//      button=4'h6, one key_valid pulse; release -> is_pressed_next=0 within
//      66 cycles and button stays 6.
//   3. Key '0' bouncing (toggling every 5 cycles for 40 cycles), then stable
//      -> no key_valid during the bounce; exactly one pulse afterwards with button=0.
//   4. Keys '1' and '5' together -> is_pressed_next stays 0; release '1'
//      -> '5' is accepted (button=5, one pulse).
//   5. Hold '7', then switch to '8' with no release -> button stays 7 and
//      is_pressed_next stays 1; release all, then press '8' -> new pulse, button=8.
//   6. Hold 'E' and reach is_pressed_next=1, then reset for 3 cycles while
//      'E' is still held -> outputs clear asynchronously; 'E' is re-accepted
//      within 66 cycles after reset is released.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad-side and control-unit-side signals of the 4x4 keypad scanner.
// master = scanner (drives columns and key outputs), slave = keypad model / consumer.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] button;
    logic       is_pressed_next;
    logic       key_valid;

    modport master (
        input  row,
        output col,
        output button,
        output is_pressed_next,
        output key_valid
    );

    modport slave (
        output row,
        input  col,
        input  button,
        input  is_pressed_next,
        input  key_valid
    );
endinterface

// File: rtl/keypad_scanner.sv
// Scans and debounces a 4x4 active-low keypad into a held key code and pressed level.
// Accepts a change after DEBOUNCE_SCANS identical full scans (4*SCAN_DIV cycles each); no backpressure.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clock,
    input  logic              reset,
    keypad_scanner_if.master  kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic {IDLE, PRESSED} state_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [1:0]    cidx;
    logic [DW-1:0] dwell;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;
    logic          prev_key;
    logic [3:0]    prev_code;
    logic [SW-1:0] stable_cnt;
    state_t        state;
    logic [3:0]    button;
    logic          is_pressed_next;
    logic          key_valid;

    logic [1:0]    col_cnt;
    logic [1:0]    col_row;
    logic [2:0]    sum;
    logic [1:0]    tot_cnt;
    logic [3:0]    tot_code;
    logic          res_key;
    logic          same;
    logic [SW-1:0] next_stable;
    logic          is_stable;
    logic          sample;
    logic          scan_end;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hF;  4'hD: code = 4'h0;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Low-bit count is saturated at 2: anything beyond one key is simply "ghost".
    always_comb begin
        col_cnt = 2'd0;
        col_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_row = 2'(r);
                if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
            end
        end
        sum         = {1'b0, acc_cnt} + {1'b0, col_cnt};
        tot_cnt     = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        tot_code    = (col_cnt == 2'd1) ? keymap(col_row, cidx) : acc_code;
        res_key     = (tot_cnt == 2'd1);
        same        = (res_key == prev_key) && (!res_key || tot_code == prev_code);
        next_stable = !same ? SW'(1)
                    : (stable_cnt == SW'(DEBOUNCE_SCANS)) ? stable_cnt
                    : stable_cnt + SW'(1);
        is_stable   = (next_stable == SW'(DEBOUNCE_SCANS));
        sample      = (dwell == DW'(SCAN_DIV - 1));
        scan_end    = sample && (cidx == 2'd3);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta        <= 4'hF;
            row_sync        <= 4'hF;
            cidx            <= 2'd0;
            dwell           <= '0;
            acc_cnt         <= 2'd0;
            acc_code        <= 4'h0;
            prev_key        <= 1'b0;
            prev_code       <= 4'h0;
            stable_cnt      <= '0;
            state           <= IDLE;
            button          <= 4'h0;
            is_pressed_next <= 1'b0;
            key_valid       <= 1'b0;
        end else begin
            row_meta  <= kp.row;
            row_sync  <= row_meta;
            key_valid <= 1'b0;
            if (sample) begin
                dwell <= '0;
                cidx  <= cidx + 2'd1;
                if (scan_end) begin
                    acc_cnt    <= 2'd0;
                    acc_code   <= 4'h0;
                    prev_key   <= res_key;
                    prev_code  <= tot_code;
                    stable_cnt <= next_stable;
                    case (state)
                        IDLE: begin
                            if (is_stable && res_key) begin
                                state           <= PRESSED;
                                button          <= tot_code;
                                is_pressed_next <= 1'b1;
                                key_valid       <= 1'b1;
                            end
                        end
                        PRESSED: begin
                            // A different stable key while held is ignored until released.
                            if (is_stable && !res_key) begin
                                state           <= IDLE;
                                is_pressed_next <= 1'b0;
                            end
                        end
                    endcase
                end else begin
                    acc_cnt  <= tot_cnt;
                    acc_code <= tot_code;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    assign kp.col             = ~(4'b0001 << cidx);
    assign kp.button          = button;
    assign kp.is_pressed_next = is_pressed_next;
    assign kp.key_valid       = key_valid;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scan).
module tb_keypad_scanner;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] keys;   // bit r*4+c = key at row r, column c held
    int          errors = 0;
    int          checks = 0;
    int          kv_count = 0;
    int          base;

    localparam int K1 = 0;   // r0c0
    localparam int K5 = 5;   // r1c1
    localparam int K6 = 6;   // r1c2
    localparam int K7 = 8;   // r2c0
    localparam int K8 = 9;   // r2c1
    localparam int K0 = 13;  // r3c1
    localparam int KE = 14;  // r3c2

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clock (clock),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clock = ~clock;

    // Passive matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        kp.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
    end

    always @(negedge clock) if (kp.key_valid === 1'b1) kv_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_level(input string tag, input logic lvl, input int limit);
        int n = 0;
        while (kp.is_pressed_next !== lvl && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(tag, {31'd0, kp.is_pressed_next}, {31'd0, lvl});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        keys  = 16'h0;
        reset = 1'b1;
        idle(2);
        check("rst_col",     kp.col, 4'b1110);
        check("rst_button",  kp.button, 4'h0);
        check("rst_pressed", kp.is_pressed_next, 1'b0);
        check("rst_kv",      kp.key_valid, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] e;
            e = ~(4'b0001 << (i / 4));
            check("col_rot", kp.col, e);
            @(negedge clock);
        end

        // Single key '6'
        base = kv_count;
        keys[K6] = 1'b1;
        wait_level("press6", 1'b1, 66);
        check("button6", kp.button, 4'h6);
        idle(20);
        check("kv6", kv_count - base, 1);
        keys = 16'h0;
        wait_level("rel6", 1'b0, 66);
        check("button6_hold", kp.button, 4'h6);
        check("kv6_rel", kv_count - base, 1);

        // Bouncing '0' then stable
        base = kv_count;
        for (int i = 0; i < 8; i++) begin
            keys[K0] = (i % 2 == 0);
            idle(5);
        end
        check("bounce_kv", kv_count - base, 0);
        keys[K0] = 1'b1;
        wait_level("press0", 1'b1, 66);
        idle(4);
        check("button0", kp.button, 4'h0);
        check("kv0", kv_count - base, 1);
        keys = 16'h0;
        wait_level("rel0", 1'b0, 66);

        // Two keys rejected, survivor accepted
        base = kv_count;
        keys[K1] = 1'b1;
        keys[K5] = 1'b1;
        idle(80);
        check("ghost_pressed", kp.is_pressed_next, 1'b0);
        check("ghost_kv", kv_count - base, 0);
        keys[K1] = 1'b0;
        wait_level("press5", 1'b1, 66);
        idle(4);
        check("button5", kp.button, 4'h5);
        check("kv5", kv_count - base, 1);
        keys = 16'h0;
        wait_level("rel5", 1'b0, 66);

        // Roll from '7' to '8' without release is ignored
        base = kv_count;
        keys[K7] = 1'b1;
        wait_level("press7", 1'b1, 66);
        idle(4);
        check("button7", kp.button, 4'h7);
        check("kv7", kv_count - base, 1);
        keys[K7] = 1'b0;
        keys[K8] = 1'b1;
        idle(100);
        check("roll_button", kp.button, 4'h7);
        check("roll_pressed", kp.is_pressed_next, 1'b1);
        check("roll_kv", kv_count - base, 1);
        keys = 16'h0;
        wait_level("rel7", 1'b0, 66);
        base = kv_count;
        keys[K8] = 1'b1;
        wait_level("press8", 1'b1, 66);
        idle(4);
        check("button8", kp.button, 4'h8);
        check("kv8", kv_count - base, 1);
        keys = 16'h0;
        wait_level("rel8", 1'b0, 66);

        // Reset while 'E' is held
        keys[KE] = 1'b1;
        wait_level("pressE", 1'b1, 66);
        check("buttonE", kp.button, 4'hE);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_button",  kp.button, 4'h0);
        check("mid_rst_pressed", kp.is_pressed_next, 1'b0);
        check("mid_rst_kv",      kp.key_valid, 1'b0);
        check("mid_rst_col",     kp.col, 4'b1110);
        idle(3);
        reset = 1'b0;
        base = kv_count;
        wait_level("repressE", 1'b1, 66);
        idle(4);
        check("buttonE_again", kp.button, 4'hE);
        check("kvE_again", kv_count - base, 1);
        keys = 16'h0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
